// File: rtl/tempsense_sched_if.sv
// Host/core signal bundle for tempsense_sched: slave modport faces the scheduler,
// master modport faces the host register block and core wrapper.
interface tempsense_sched_if #(
    parameter int unsigned PERIOD_W = 16
);
    logic                start_i;
    logic                cont_en_i;
    logic [PERIOD_W-1:0] period_i;
    logic                done_i;
    logic [7:0]          ib_i;
    logic [7:0]          ibf_i;
    logic                core_rst_o;
    logic [7:0]          res_o;
    logic [7:0]          ib_o;
    logic                res_valid_o;
    logic                res_ready_i;
    logic                busy_o;
    logic                err_o;
    logic [7:0]          min_o;
    logic [7:0]          max_o;

    modport slave (
        input  start_i, cont_en_i, period_i, done_i, ib_i, ibf_i, res_ready_i,
        output core_rst_o, res_o, ib_o, res_valid_o, busy_o, err_o, min_o, max_o
    );

    modport master (
        output start_i, cont_en_i, period_i, done_i, ib_i, ibf_i, res_ready_i,
        input  core_rst_o, res_o, ib_o, res_valid_o, busy_o, err_o, min_o, max_o
    );
endinterface

// File: rtl/tempsense_sched.sv
// Temperature-sense measurement scheduler: owns core reset, averages 2^AVG_LOG2 fine codes per set.
// Optional per-set min/max tracking is built when TSCHED_MINMAX_EN is defined.
module tempsense_sched #(
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned TIMEOUT  = 4095,
    parameter int unsigned PERIOD_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    tempsense_sched_if.slave   bus
);
    localparam int unsigned ACC_W = 8 + AVG_LOG2;
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam int unsigned NSAMP = 1 << AVG_LOG2;
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_done_q;
    logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
    logic [ACC_W-1:0]    r_acc, w_acc_nxt;
    logic [TMO_W-1:0]    r_tmo, w_tmo_nxt;
    logic [PERIOD_W-1:0] r_gap, w_gap_nxt;
    logic [7:0]          r_res, w_res_nxt;
    logic [7:0]          r_ib, w_ib_nxt;
    logic                r_valid, w_valid_nxt;
    logic                r_err, w_err_nxt;
    logic                r_core_rst;
    logic                r_busy;
    logic                w_sample;
    logic                w_last;
    logic                w_fresh;
    logic [ACC_W-1:0]    w_sum;

    // Rising edge of the core strobe, only counted while a set is being collected
    assign w_sample = (r_state == ST_WAIT) && bus.done_i && !r_done_q;
    assign w_last   = (r_cnt == CNT_W'(NSAMP - 1));
    assign w_sum    = r_acc + ACC_W'(bus.ibf_i);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_done_q   <= 1'b0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_tmo      <= '0;
            r_gap      <= '0;
            r_res      <= '0;
            r_ib       <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_core_rst <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_done_q   <= bus.done_i;
            r_cnt      <= w_cnt_nxt;
            r_acc      <= w_acc_nxt;
            r_tmo      <= w_tmo_nxt;
            r_gap      <= w_gap_nxt;
            r_res      <= w_res_nxt;
            r_ib       <= w_ib_nxt;
            r_valid    <= w_valid_nxt;
            r_err      <= w_err_nxt;
            r_core_rst <= (w_state_nxt != ST_WAIT);
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        w_tmo_nxt   = r_tmo;
        w_gap_nxt   = r_gap;
        w_res_nxt   = r_res;
        w_ib_nxt    = r_ib;
        w_valid_nxt = r_valid;
        w_err_nxt   = r_err;
        w_fresh     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start_i || bus.cont_en_i) begin
                    w_err_nxt   = 1'b0;
                    w_fresh     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A sample beats a timeout expiring in the same cycle
                if (w_sample) begin
                    w_acc_nxt = w_sum;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_tmo_nxt = TMO_W'(TIMEOUT);
                    if (r_cnt == '0) begin
                        w_ib_nxt = bus.ib_i;
                    end
                    if (w_last) begin
                        w_res_nxt   = 8'(w_sum >> AVG_LOG2);
                        w_valid_nxt = 1'b1;
                        w_state_nxt = ST_DONE;
                    end
                end else if (r_tmo <= TMO_W'(1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_tmo_nxt = r_tmo - TMO_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.res_ready_i) begin
                    w_valid_nxt = 1'b0;
                    if (bus.cont_en_i && (bus.period_i != '0)) begin
                        w_gap_nxt   = bus.period_i;
                        w_state_nxt = ST_GAP;
                    end else if (bus.cont_en_i) begin
                        w_fresh     = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (!bus.cont_en_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_gap <= PERIOD_W'(1)) begin
                    w_fresh     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_gap_nxt = r_gap - PERIOD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Every new set starts with an empty accumulator and a full timeout budget
        if (w_fresh) begin
            w_cnt_nxt = '0;
            w_acc_nxt = '0;
            w_tmo_nxt = TMO_W'(TIMEOUT);
        end
    end

`ifdef TSCHED_MINMAX_EN
    logic [7:0] r_min_run, r_max_run;
    logic [7:0] r_min, r_max;
    logic [7:0] w_min_cur, w_max_cur;

    assign w_min_cur = ((r_cnt == '0) || (bus.ibf_i < r_min_run)) ? bus.ibf_i : r_min_run;
    assign w_max_cur = ((r_cnt == '0) || (bus.ibf_i > r_max_run)) ? bus.ibf_i : r_max_run;

    // Running extremes are published together with the averaged result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_min_run <= '0;
            r_max_run <= '0;
            r_min     <= '0;
            r_max     <= '0;
        end else if (w_sample) begin
            r_min_run <= w_min_cur;
            r_max_run <= w_max_cur;
            if (w_last) begin
                r_min <= w_min_cur;
                r_max <= w_max_cur;
            end
        end
    end

    assign bus.min_o = r_min;
    assign bus.max_o = r_max;
`else
    assign bus.min_o = '0;
    assign bus.max_o = '0;
`endif

    assign bus.core_rst_o  = r_core_rst;
    assign bus.res_o       = r_res;
    assign bus.ib_o        = r_ib;
    assign bus.res_valid_o = r_valid;
    assign bus.busy_o      = r_busy;
    assign bus.err_o       = r_err;
endmodule

// File: tb/tb_tempsense_sched.sv
// Directed bench for tempsense_sched (AVG_LOG2=2, TIMEOUT=20): vector table plus corner sequences.
module tb_tempsense_sched;
    localparam int unsigned PW = 16;

`ifdef TSCHED_MINMAX_EN
    localparam bit MM_EN = 1'b1;
`else
    localparam bit MM_EN = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;

    tempsense_sched_if #(.PERIOD_W(PW)) bus ();

    tempsense_sched #(
        .AVG_LOG2(2),
        .TIMEOUT (20),
        .PERIOD_W(PW)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] s0;
        logic [7:0] s1;
        logic [7:0] s2;
        logic [7:0] s3;
        logic [7:0] ib0;
        logic [7:0] res;
        logic [7:0] mn;
        logic [7:0] mx;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    // One core sample: done_i high for one cycle, then low for one cycle
    task automatic samp(input logic [7:0] ibf, input logic [7:0] ib);
        bus.ibf_i  = ibf;
        bus.ib_i   = ib;
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        tick();
    endtask

    // Last sample of a set: leaves the bench one cycle after the sampled edge
    task automatic samp_last(input logic [7:0] ibf, input logic [7:0] ib);
        bus.ibf_i  = ibf;
        bus.ib_i   = ib;
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        checkb({tag, "_core_rst"}, bus.core_rst_o, 1'b1);
        checkb({tag, "_busy"},     bus.busy_o, 1'b0);
        checkb({tag, "_valid"},    bus.res_valid_o, 1'b0);
        checkb({tag, "_err"},      bus.err_o, 1'b0);
        check8({tag, "_res"},      bus.res_o, 8'h00);
        check8({tag, "_ib"},       bus.ib_o, 8'h00);
        check8({tag, "_min"},      bus.min_o, 8'h00);
        check8({tag, "_max"},      bus.max_o, 8'h00);
    endtask

    initial begin
        int cnt;

        vecs[0] = '{s0: 8'h80, s1: 8'h81, s2: 8'h83, s3: 8'h82, ib0: 8'h11, res: 8'h81, mn: 8'h80, mx: 8'h83};
        vecs[1] = '{s0: 8'h70, s1: 8'h90, s2: 8'h80, s3: 8'h88, ib0: 8'h22, res: 8'h82, mn: 8'h70, mx: 8'h90};
        vecs[2] = '{s0: 8'hFF, s1: 8'hFF, s2: 8'hFF, s3: 8'hFF, ib0: 8'hFE, res: 8'hFF, mn: 8'hFF, mx: 8'hFF};
        vecs[3] = '{s0: 8'h00, s1: 8'h00, s2: 8'h00, s3: 8'h03, ib0: 8'h00, res: 8'h00, mn: 8'h00, mx: 8'h03};
        vecs[4] = '{s0: 8'h04, s1: 8'h01, s2: 8'h03, s3: 8'h02, ib0: 8'hA5, res: 8'h02, mn: 8'h01, mx: 8'h04};

        reset_n         = 1'b0;
        bus.start_i     = 1'b0;
        bus.cont_en_i   = 1'b0;
        bus.period_i    = '0;
        bus.done_i      = 1'b0;
        bus.ib_i        = '0;
        bus.ibf_i       = '0;
        bus.res_ready_i = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst");
        reset_n = 1'b1;
        tick();

        // Single-shot sets from the vector table
        for (int i = 0; i < 5; i++) begin
            pulse_start();
            checkb($sformatf("v%0d_core_rst_wait", i), bus.core_rst_o, 1'b0);
            checkb($sformatf("v%0d_busy_wait", i), bus.busy_o, 1'b1);
            samp(vecs[i].s0, vecs[i].ib0);
            samp(vecs[i].s1, 8'(vecs[i].ib0 + 8'd1));
            samp(vecs[i].s2, 8'(vecs[i].ib0 + 8'd2));
            checkb($sformatf("v%0d_valid_early", i), bus.res_valid_o, 1'b0);
            samp_last(vecs[i].s3, 8'(vecs[i].ib0 + 8'd3));
            checkb($sformatf("v%0d_valid", i), bus.res_valid_o, 1'b1);
            check8($sformatf("v%0d_res", i), bus.res_o, vecs[i].res);
            check8($sformatf("v%0d_ib", i), bus.ib_o, vecs[i].ib0);
            check8($sformatf("v%0d_min", i), bus.min_o, MM_EN ? vecs[i].mn : 8'h00);
            check8($sformatf("v%0d_max", i), bus.max_o, MM_EN ? vecs[i].mx : 8'h00);
            checkb($sformatf("v%0d_core_rst_done", i), bus.core_rst_o, 1'b1);
            tick();
            checkb($sformatf("v%0d_valid_hold", i), bus.res_valid_o, 1'b1);
            bus.res_ready_i = 1'b1;
            tick();
            bus.res_ready_i = 1'b0;
            checkb($sformatf("v%0d_valid_clr", i), bus.res_valid_o, 1'b0);
            checkb($sformatf("v%0d_busy_idle", i), bus.busy_o, 1'b0);
        end

        // Backpressure: core keeps pulsing for 50 cycles while the result waits
        pulse_start();
        samp(8'h80, 8'h11);
        samp(8'h81, 8'h12);
        samp(8'h83, 8'h13);
        samp_last(8'h82, 8'h14);
        for (int k = 0; k < 25; k++) samp(8'h00, 8'h77);
        checkb("bp_valid", bus.res_valid_o, 1'b1);
        check8("bp_res", bus.res_o, 8'h81);
        check8("bp_ib", bus.ib_o, 8'h11);
        bus.res_ready_i = 1'b1;
        tick();
        bus.res_ready_i = 1'b0;
        checkb("bp_valid_clr", bus.res_valid_o, 1'b0);
        pulse_start();
        for (int k = 0; k < 3; k++) samp(8'h40, 8'h01);
        samp_last(8'h40, 8'h01);
        check8("bp_next_res", bus.res_o, 8'h40);
        bus.res_ready_i = 1'b1;
        tick();

        // Continuous mode, period 10: core held in reset for DONE + 10 GAP cycles
        bus.cont_en_i = 1'b1;
        bus.period_i  = PW'(10);
        tick();
        checkb("cont_core_rst_wait", bus.core_rst_o, 1'b0);
        samp(8'h20, 8'h05);
        samp(8'h22, 8'h06);
        samp(8'h24, 8'h07);
        samp_last(8'h26, 8'h08);
        checkb("cont_valid1", bus.res_valid_o, 1'b1);
        check8("cont_res1", bus.res_o, 8'h23);
        cnt = 0;
        for (int k = 0; k < 100 && bus.core_rst_o; k++) begin
            cnt++;
            tick();
        end
        check8("cont_gap_len", 8'(cnt), 8'd11);
        checkb("cont_busy_set2", bus.busy_o, 1'b1);
        samp(8'h10, 8'h09);
        samp(8'h10, 8'h0A);
        samp(8'h10, 8'h0B);
        samp_last(8'h11, 8'h0C);
        check8("cont_res2", bus.res_o, 8'h10);
        check8("cont_ib2", bus.ib_o, 8'h09);
        tick();
        tick();
        bus.cont_en_i = 1'b0;
        tick();
        checkb("cont_gap_exit_busy", bus.busy_o, 1'b0);
        checkb("cont_gap_exit_rst", bus.core_rst_o, 1'b1);
        tick();
        checkb("cont_idle_stays", bus.busy_o, 1'b0);

        // Continuous with period 0: one DONE cycle then straight back to WAIT
        bus.cont_en_i = 1'b1;
        bus.period_i  = '0;
        tick();
        for (int k = 0; k < 3; k++) samp(8'h60, 8'h02);
        samp_last(8'h64, 8'h02);
        check8("p0_res1", bus.res_o, 8'h61);
        cnt = 0;
        for (int k = 0; k < 100 && bus.core_rst_o; k++) begin
            cnt++;
            tick();
        end
        check8("p0_gap_len", 8'(cnt), 8'd1);
        bus.cont_en_i = 1'b0;
        for (int k = 0; k < 3; k++) samp(8'h08, 8'h03);
        samp_last(8'h0C, 8'h03);
        checkb("p0_finish_valid", bus.res_valid_o, 1'b1);
        check8("p0_finish_res", bus.res_o, 8'h09);
        tick();
        checkb("p0_finish_idle", bus.busy_o, 1'b0);

        // Timeout: 20 WAIT cycles without a sample
        pulse_start();
        repeat (19) tick();
        checkb("tmo_err_before", bus.err_o, 1'b0);
        checkb("tmo_busy_before", bus.busy_o, 1'b1);
        tick();
        checkb("tmo_err", bus.err_o, 1'b1);
        checkb("tmo_busy", bus.busy_o, 1'b0);
        checkb("tmo_valid", bus.res_valid_o, 1'b0);
        checkb("tmo_core_rst", bus.core_rst_o, 1'b1);

        // Restart clears err; a sample on the expiry edge wins; a held done counts once
        pulse_start();
        checkb("tmo_err_clr", bus.err_o, 1'b0);
        repeat (19) tick();
        bus.ibf_i  = 8'h50;
        bus.ib_i   = 8'h33;
        bus.done_i = 1'b1;
        tick();
        checkb("race_err", bus.err_o, 1'b0);
        checkb("race_busy", bus.busy_o, 1'b1);
        repeat (5) tick();
        bus.done_i = 1'b0;
        tick();
        samp(8'h50, 8'h34);
        samp(8'h50, 8'h35);
        checkb("held_valid_early", bus.res_valid_o, 1'b0);
        samp_last(8'h54, 8'h36);
        checkb("held_valid", bus.res_valid_o, 1'b1);
        check8("held_res", bus.res_o, 8'h51);
        check8("held_ib", bus.ib_o, 8'h33);
        tick();
        checkb("early_ready_clr", bus.res_valid_o, 1'b0);
        bus.res_ready_i = 1'b0;

        // Asynchronous reset in the middle of a set
        pulse_start();
        samp(8'hFF, 8'h44);
        samp(8'hFF, 8'h44);
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        pulse_start();
        for (int k = 0; k < 3; k++) samp(8'h10, 8'h55);
        samp_last(8'h14, 8'h55);
        checkb("post_rst_valid", bus.res_valid_o, 1'b1);
        check8("post_rst_res", bus.res_o, 8'h11);
        check8("post_rst_ib", bus.ib_o, 8'h55);
        bus.res_ready_i = 1'b1;
        tick();
        checkb("post_rst_idle", bus.busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/tempsense_sched.md
# tempsense_sched

Measurement scheduler for the temperature-sense SAR core. It releases the core from reset and collects a burst of 2^AVG_LOG2 fine-code samples, one per core output event. It averages them and presents the result to the host through a valid/ready handshake, in single-shot or continuous (periodic) mode. It sits between the host register interface and the core, and owns the core's reset, so every measurement set starts from a fresh coarse+fine conversion.

## Interface
Parameters:
- AVG_LOG2, 2, log2 of samples averaged per set (0..4)
- TIMEOUT, 4095, max cycles allowed between core release or sample and the next sample
- PERIOD_W, 16, width of the continuous-mode gap counter

Ports:
- clk  in  1  system clock (10 MHz)
- reset_n  in  1  asynchronous active-low reset
- start_i  in  1  single-shot request (level sampled each cycle in IDLE)
- cont_en_i  in  1  continuous mode enable
- period_i  in  PERIOD_W  idle cycles between sets in continuous mode
- done_i  in  1  core sample strobe (core idac_o[0])
- ib_i  in  8  core coarse code
- ibf_i  in  8  core fine code
- core_rst_o  out  1  active-high reset to core
- res_o  out  8  averaged fine code
- ib_o  out  8  coarse code captured at first sample of set
- res_valid_o  out  1  result valid
- res_ready_i  in  1  host accepts result
- busy_o  out  1  set in progress (state != IDLE)
- err_o  out  1  sticky timeout error
- min_o, max_o  out  8 each  per-set extremes (see Configuration)

## Operation
- States: IDLE, WAIT, DONE, GAP.
- IDLE: core_rst_o=1. If start_i or cont_en_i, then clear err_o, clear accumulator/sample count, load timeout counter, go to WAIT.
- WAIT: core_rst_o=0. A rising edge of done_i (done_i=1 and registered done_q=0) is a sample.
  - On a sample, add ibf_i into the accumulator (width 8+AVG_LOG2, no overflow possible) and increment the sample count.
  - On the first sample, capture ib_i into ib_o.
  - Each sample reloads the timeout counter.
  - On sample number 2^AVG_LOG2, load res_o = (sum including this sample) >> AVG_LOG2 (truncating), set res_valid_o, go to DONE.
- Timeout: the counter decrements every WAIT cycle without a sample. On reaching 0, set err_o=1 and go to IDLE. res_valid_o is not asserted and partial sums are discarded.
- DONE: core_rst_o=1. res_valid_o holds with res_o, ib_o and min/max stable until res_ready_i=1.
  - On acceptance, clear res_valid_o.
  - Then: if cont_en_i=1 and period_i>0, go to GAP (counter=period_i). If cont_en_i=1 and period_i=0, go to WAIT directly (fresh set). Otherwise go to IDLE.
- GAP: core_rst_o=1. Decrement the counter; at 1, go to WAIT with a fresh set. If cont_en_i drops during GAP, go to IDLE next cycle.
- If cont_en_i drops during WAIT, the current set completes normally; DONE then exits to IDLE.
- start_i is ignored outside IDLE. No result is ever overwritten before acceptance.

## Timing
- Reset values:
  - state=IDLE, core_rst_o=1, res_o=0, ib_o=0, res_valid_o=0, busy_o=0, err_o=0, min_o=0, max_o=0, done_q=0.
  - Sample count, accumulator, timeout counter and gap counter are all 0.
- All outputs are registered.
- IDLE->WAIT: 1 cycle after start_i is sampled high. core_rst_o falls on that same edge.
- Sample to result: res_valid_o rises on the clock edge after the final done_i rising edge is sampled (1-cycle latency).
- Acceptance: if res_valid_o=1 and res_ready_i=1 at an edge, res_valid_o=0 after that edge. res_ready_i is allowed high before valid.
- A done_i held high counts once. done_i edges in DONE/GAP/IDLE are ignored, but done_q still tracks the input.
- If a sample and timeout expiry fall in the same cycle, the sample wins.
- reset_n asserted mid-set: immediate return to reset values, core held in reset.

## Configuration
- TSCHED_MINMAX_EN defined:
  - min_o/max_o track the smallest/largest ibf_i sample of the current set.
  - Both are initialised from the first sample and are updated with res_o.
- Not defined: min_o=max_o=0 constantly; no tracking registers are synthesised.

## Test plan
- Single shot, AVG_LOG2=2: start_i pulse, core model emits done_i with ibf 0x80,0x81,0x83,0x82 -> res_o=0x81, res_valid_o 1 cycle after the 4th edge, core_rst_o=1 in DONE, busy_o=0 after ready.
- Backpressure: hold res_ready_i=0 for 50 cycles while done_i keeps pulsing -> res_o unchanged, no extra accumulation, valid stays high.
- Continuous, period_i=10: cont_en_i=1 and ready tied high -> core_rst_o high exactly 1 (DONE)+10 (GAP) cycles between sets. Deassert cont_en_i in GAP -> IDLE next cycle.
- Timeout, TIMEOUT=20: start_i with no done_i -> err_o=1 at cycle 21, state IDLE, res_valid_o=0. Next start_i clears err_o.
- Reset mid-set: reset_n low after 2 samples -> all outputs at reset values. A new start yields an average from fresh samples only.
- TSCHED_MINMAX_EN: samples 0x70,0x90,0x80,0x88 -> min_o=0x70, max_o=0x90, res_o=0x82. Without the macro -> min_o=max_o=0.
